// File: rtl/ad5791_readback_rx_if.sv
// ad5791_readback_rx_if: valid/ready channel carrying captured readback words.
interface ad5791_readback_rx_if #(
    parameter int FRAME_BITS = 24
);
    logic [FRAME_BITS-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    modport master (output rd_data, rd_valid, input rd_ready);
    modport slave  (input rd_data, rd_valid, output rd_ready);
endinterface

// File: rtl/ad5791_readback_rx.sv
// ad5791_readback_rx: oversampled AD5791 SDO readback deserialiser with a one-word valid/ready buffer.
// Optional AD5791_RX_GLITCH_FILTER_EN: 2-sample filter on PMD_clk/PMD_sync, adding one cycle of latency.
module ad5791_readback_rx #(
    parameter int FRAME_BITS  = 24,
    parameter int SYNC_STAGES = 2,
    parameter bit SAMPLE_EDGE = 1'b0
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        PMD_clk,
    input  logic                        PMD_sync,
    input  logic                        PMD_sdo,
    input  logic                        capture_en,
    ad5791_readback_rx_if.master        rd,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        overrun_clr,
    output logic [15:0]                 frame_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    localparam logic [5:0] FULL = 6'(FRAME_BITS);
    localparam logic [5:0] SAT  = 6'(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] clk_sr, sync_sr, sdo_sr;
    logic clk_f, sync_f, sdo_f;
    logic clk_d, sync_d, sdo_q;
    logic clk_edge, sync_rise, sync_fall;

    state_t                state, state_n;
    logic [5:0]            bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n, data_n;
    logic                  valid_n, err_n, ovr_n, good, load;
    logic [15:0]           count_n;

    // Bring the DAC pin copies into the aclk domain; SYNC idles high.
    always_ff @(posedge aclk or posedge reset)
        if (reset) begin
            clk_sr  <= '0;
            sync_sr <= '1;
            sdo_sr  <= '0;
        end else begin
            clk_sr  <= {clk_sr[SYNC_STAGES-2:0], PMD_clk};
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], PMD_sync};
            sdo_sr  <= {sdo_sr[SYNC_STAGES-2:0], PMD_sdo};
        end

`ifdef AD5791_RX_GLITCH_FILTER_EN
    logic clk_p, sync_p, clk_h, sync_h, sdo_p;
    assign clk_f  = (clk_sr[SYNC_STAGES-1] == clk_p) ? clk_p : clk_h;
    assign sync_f = (sync_sr[SYNC_STAGES-1] == sync_p) ? sync_p : sync_h;
    assign sdo_f  = sdo_p;
    // A new level is accepted only once two consecutive samples agree; sdo is delayed to stay aligned.
    always_ff @(posedge aclk or posedge reset)
        if (reset) begin
            clk_p  <= 1'b0;
            sync_p <= 1'b1;
            clk_h  <= 1'b0;
            sync_h <= 1'b1;
            sdo_p  <= 1'b0;
        end else begin
            clk_p  <= clk_sr[SYNC_STAGES-1];
            sync_p <= sync_sr[SYNC_STAGES-1];
            clk_h  <= clk_f;
            sync_h <= sync_f;
            sdo_p  <= sdo_sr[SYNC_STAGES-1];
        end
`else
    assign clk_f  = clk_sr[SYNC_STAGES-1];
    assign sync_f = sync_sr[SYNC_STAGES-1];
    assign sdo_f  = sdo_sr[SYNC_STAGES-1];
`endif

    // Edge register plus registered edge pulses; sdo is captured alongside the clock pulse.
    always_ff @(posedge aclk or posedge reset)
        if (reset) begin
            clk_d     <= 1'b0;
            sync_d    <= 1'b1;
            clk_edge  <= 1'b0;
            sync_rise <= 1'b0;
            sync_fall <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            clk_d     <= clk_f;
            sync_d    <= sync_f;
            clk_edge  <= SAMPLE_EDGE ? (clk_f & ~clk_d) : (~clk_f & clk_d);
            sync_rise <= sync_f & ~sync_d;
            sync_fall <= ~sync_f & sync_d;
            sdo_q     <= sdo_f;
        end

    // Frame FSM, buffer handshake and status next-state logic.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        good      = (state == CHECK) && (bit_cnt == FULL);
        load      = good && (!rd.rd_valid || rd.rd_ready);
        err_n     = (state == CHECK) && (bit_cnt != FULL);
        data_n    = load ? shreg : rd.rd_data;
        valid_n   = load || (rd.rd_valid && !rd.rd_ready);
        ovr_n     = (good && !load) || (overrun && !overrun_clr);
        count_n   = frame_count + 16'(load);
        case (state)
            IDLE: if (sync_fall && capture_en) begin
                state_n   = SHIFT;
                bit_cnt_n = '0;
                shreg_n   = '0;
            end
            SHIFT: if (sync_rise) begin
                state_n = CHECK;
            end else if (clk_edge) begin
                shreg_n   = {shreg[FRAME_BITS-2:0], sdo_q};
                bit_cnt_n = (bit_cnt == SAT) ? SAT : bit_cnt + 6'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge aclk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            rd.rd_data  <= data_n;
            rd.rd_valid <= valid_n;
            frame_err   <= err_n;
            overrun     <= ovr_n;
            frame_count <= count_n;
        end
endmodule

// File: doc/ad5791_readback_rx.md
Name: ad5791_readback_rx

Overview:
- Receive side of the AD5791 serial interface: captures DAC readback frames shifted out on the common SDO line.
- Runs in the `aclk` domain and oversamples the DAC serial clock and SYNC, which are the same signals that drive the DAC pins.
- Deserialises each 24-bit frame MSB-first and hands the word to the controller or PS over a valid/ready handshake.
- Flags malformed frames and overruns, so register readback (ctrl/clearcode/DAC value) can be verified against what was written.

Parameters:
- FRAME_BITS, 24: bits per valid frame; `rd_data` width.
- SYNC_STAGES, 2: synchroniser flops on `PMD_clk`, `PMD_sync` and `PMD_sdo` (minimum 2).
- SAMPLE_EDGE, 0: 0 = sample SDO on falling `PMD_clk`; 1 = sample on rising.

Ports:
- `aclk` in 1: system clock; must be ≥ 4× the `PMD_clk` frequency.
- `reset` in 1: asynchronous, active-high; clears all state.
- `PMD_clk` in 1: DAC serial clock (fabric copy of the clock driven to the pin).
- `PMD_sync` in 1: DAC SYNC, active-low frame envelope.
- `PMD_sdo` in 1: common SDO readback line from the DACs.
- `capture_en` in 1: arm capture; sampled at frame start.
- `rd_data` out FRAME_BITS: captured word; [23] R/W, [22:20] address, [19:0] data.
- `rd_valid` out 1: `rd_data` holds an unconsumed word.
- `rd_ready` in 1: consumer accepts the word.
- `frame_err` out 1: one-cycle pulse when a captured frame length is not FRAME_BITS.
- `overrun` out 1: sticky; a good frame was dropped because the buffer was full.
- `overrun_clr` in 1: clears `overrun`.
- `frame_count` out 16: good frames accepted into the buffer; wraps 0xFFFF→0.

Behaviour:
- Reset values: `rd_data`=0, `rd_valid`=0, `frame_err`=0, `overrun`=0, `frame_count`=0, FSM=IDLE.
- Synchroniser reset values: `PMD_sync` flops and its edge register =1; `PMD_clk` and `PMD_sdo` flops =0.
- Synchronisers: SYNC_STAGES flops per input, then one edge-detect register. Edges:
  - `sync_fall`, `sync_rise` from the synchronised `PMD_sync`;
  - `clk_edge` from the synchronised `PMD_clk`, per SAMPLE_EDGE.
- IDLE:
  - On `sync_fall` with `capture_en`=1: go to SHIFT; `bit_cnt`←0, `shreg`←0.
  - On `sync_fall` with `capture_en`=0: frame ignored, stay IDLE.
  - `capture_en` is not looked at after frame start.
- SHIFT:
  - On `clk_edge`: `shreg`←{`shreg`[FRAME_BITS-2:0], `sdo_s`}; `bit_cnt`++, saturating at FRAME_BITS+1 (6-bit counter).
  - On `sync_rise`: go to CHECK. If `clk_edge` and `sync_rise` coincide, `sync_rise` wins and that edge is not shifted.
- CHECK (exactly one cycle), then always return to IDLE:
  - `bit_cnt`≠FRAME_BITS: pulse `frame_err`; buffer untouched.
  - `bit_cnt`=FRAME_BITS and (`rd_valid`=0 or `rd_ready`=1 this cycle): `rd_data`←`shreg`, `rd_valid`←1, `frame_count`++.
  - `bit_cnt`=FRAME_BITS and `rd_valid`=1 and `rd_ready`=0: word dropped, `overrun`←1, `rd_data` unchanged.
- Handshake:
  - Transfer occurs when `rd_valid` & `rd_ready` on a rising `aclk`.
  - `rd_valid` falls the next cycle unless CHECK loads a new word in that same cycle, in which case `rd_valid` stays 1 with the new data.
  - `rd_data` is stable while `rd_valid`=1 and no transfer occurs.
- Latency: `rd_valid` rises exactly SYNC_STAGES+3 `aclk` edges after the first edge that samples `PMD_sync` high at frame end.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- Reset mid-frame: frame abandoned, FSM returns to IDLE. A new frame requires `PMD_sync` high then falling. Since the `sync` registers reset to 1, a SYNC that is already low when reset releases never starts a frame.
- `bit_cnt` never wraps, so a 64-bit frame is reported as an error, not accepted.

Optional Feature:
- AD5791_RX_GLITCH_FILTER_EN
- Defined: a 2-sample majority filter follows the synchronisers on `PMD_clk` and `PMD_sync`. A level change is accepted only after 2 consecutive equal samples. Single-cycle glitches produce no edges. Latency rises to SYNC_STAGES+4.
- Undefined: filter absent; every synchronised transition is an edge.

Test Plan:
- `capture_en`=1, 24-bit frame 0x9ABCDE at `PMD_clk`=`aclk`/4, falling-edge sample → `rd_data`=0x9ABCDE, `rd_valid`=1 at SYNC_STAGES+3 after SYNC rise, `frame_count`=1, `frame_err`=0.
- Frames of 23 and 25 bits → one `frame_err` pulse each, `rd_valid` stays 0, `frame_count` unchanged.
- Hold `rd_ready`=0, send 0x111111 then 0x222222 → `rd_data`=0x111111, `overrun`=1, `frame_count`=1. Then `rd_ready`=1 for 1 cycle → `rd_valid`=0. Then `overrun_clr` → `overrun`=0.
- `capture_en`=0 at SYNC fall, raised mid-frame → frame ignored, no `rd_valid`, no `frame_err`.
- Assert `reset` after 12 bits, release, send full frame 0x0F00F0 → only 0x0F00F0 captured, `frame_count`=1.
- `rd_ready`=1 exactly in the CHECK cycle of a second frame → `rd_valid` stays high, `rd_data` switches to the second word, no overrun.
